up_counter_7bit: RTL and testbench

7-bit loadable up-counter with programmable terminal value, terminal-count pulse and sticky out-of-range flag. It is the up-counting counterpart of the lab's 7-bit down counter. It drives the same 7-bit `q` bus consumers, such as display decoders and timing sequencers, and is exercised by the same clock/reset bench style.

---
 rtl/up_counter_7bit_pkg.sv | 20 ++
 rtl/up_counter_7bit_if.sv | 26 ++
 rtl/up_counter_7bit.sv | 69 ++++++
 tb/tb_up_counter_7bit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_counter_7bit_pkg.sv
// Shared types and helpers for the 7-bit up counter.
// Saturation mode is selected with UP_COUNTER_7BIT_SAT_EN.
package up_counter_pkg;

  localparam int DEF_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SAT
  } state_t;

  function automatic logic is_terminal(
    input logic [DEF_WIDTH-1:0] q,
    input logic [DEF_WIDTH-1:0] limit
  );
    return q == limit;
  endfunction

endpackage

// File: rtl/up_counter_7bit_if.sv
// Control/status bundle of the 7-bit up counter.
// Master drives controls; slave (the counter) drives status.
interface up_counter_7bit_if #(
  parameter int WIDTH = up_counter_pkg::DEF_WIDTH
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             oor;
  logic             running;

  modport master (
    output en, load, d, limit,
    input  q, tc, oor, running
  );

  modport slave (
    input  en, load, d, limit,
    output q, tc, oor, running
  );

endinterface

// File: rtl/up_counter_7bit.sv
// Loadable up counter with terminal value, tc pulse and sticky oor.
// Define UP_COUNTER_7BIT_SAT_EN to hold at limit instead of wrapping.
module up_counter_7bit
  import up_counter_pkg::*;
#(
  parameter int                WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic               clk,
  input  logic               reset,
  up_counter_7bit_if.slave   bus
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_r;
  logic             tc_nxt;
  logic             oor_r;
  logic             oor_nxt;
  logic             hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q_r   <= INIT;
      tc_r  <= 1'b0;
      oor_r <= 1'b0;
    end else begin
      state <= state_nxt;
      q_r   <= q_nxt;
      tc_r  <= tc_nxt;
      oor_r <= oor_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q_r;
    tc_nxt    = 1'b0;
    oor_nxt   = oor_r;
    hit       = is_terminal(q_r, bus.limit);
    if (bus.load) begin
      q_nxt     = bus.d;
      oor_nxt   = bus.d > bus.limit;
      state_nxt = RUN;
    end else if (bus.en && state != SAT) begin
      state_nxt = RUN;
      // q above limit never hits, so it rolls over silently
      if (hit) begin
        tc_nxt = 1'b1;
`ifdef UP_COUNTER_7BIT_SAT_EN
        state_nxt = SAT;
`else
        q_nxt = '0;
`endif
      end else begin
        q_nxt = q_r + WIDTH'(1);
      end
    end
  end

  assign bus.q       = q_r;
  assign bus.tc      = tc_r;
  assign bus.oor     = oor_r;
  assign bus.running = (state == RUN);

endmodule

// File: tb/tb_up_counter_7bit.sv
// Directed bench for up_counter_7bit, wrap or saturate build.
module tb_up_counter_7bit;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  up_counter_7bit_if #(.WIDTH(7)) bus ();

  up_counter_7bit #(
    .WIDTH(7),
    .INIT (7'd0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bus.en    = 1'b0;
    bus.load  = 1'b0;
    bus.d     = 7'd0;
    bus.limit = 7'd127;
    #5;
    total++;
    if (bus.q !== 7'd0)
      $display("FAIL reset_q got %0d want 0", bus.q);
    else passed++;
    total++;
    if (bus.tc !== 1'b0 || bus.oor !== 1'b0 || bus.running !== 1'b0)
      $display("FAIL reset_flags got tc=%b oor=%b run=%b want 000",
               bus.tc, bus.oor, bus.running);
    else passed++;
    #10;
    reset = 1'b1;
  endtask

  task automatic test_count();
    bus.en = 1'b1;
    total++;
    if (bus.q !== 7'd0 || bus.running !== 1'b0)
      $display("FAIL count_pre got q=%0d run=%b want 0 0",
               bus.q, bus.running);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      step();
      total++;
      if (bus.q !== 7'(i) || bus.running !== 1'b1 || bus.tc !== 1'b0)
        $display("FAIL count_%0d got q=%0d run=%b tc=%b want %0d 1 0",
                 i, bus.q, bus.running, bus.tc, i);
      else passed++;
    end
    bus.en = 1'b0;
    step();
    total++;
    if (bus.q !== 7'd4 || bus.tc !== 1'b0)
      $display("FAIL count_hold got q=%0d tc=%b want 4 0", bus.q, bus.tc);
    else passed++;
  endtask

`ifndef UP_COUNTER_7BIT_SAT_EN
  task automatic test_wrap();
    logic [6:0] eq;
    logic       et;
    bus.en    = 1'b0;
    bus.load  = 1'b1;
    bus.d     = 7'd0;
    bus.limit = 7'd5;
    step();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      eq = 7'((i + 1) % 6);
      et = (eq == 7'd0);
      total++;
      if (bus.q !== eq || bus.tc !== et || bus.running !== 1'b1)
        $display("FAIL wrap_%0d got q=%0d tc=%b run=%b want %0d %b 1",
                 i, bus.q, bus.tc, bus.running, eq, et);
      else passed++;
    end
    bus.en = 1'b0;
  endtask
`else
  task automatic test_sat();
    bus.en    = 1'b0;
    bus.load  = 1'b1;
    bus.d     = 7'd0;
    bus.limit = 7'd3;
    step();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (bus.q !== 7'(i) || bus.tc !== 1'b0 || bus.running !== 1'b1)
        $display("FAIL sat_up_%0d got q=%0d tc=%b run=%b want %0d 0 1",
                 i, bus.q, bus.tc, bus.running, i);
      else passed++;
    end
    step();
    total++;
    if (bus.q !== 7'd3 || bus.tc !== 1'b1 || bus.running !== 1'b0)
      $display("FAIL sat_hit got q=%0d tc=%b run=%b want 3 1 0",
               bus.q, bus.tc, bus.running);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.q !== 7'd3 || bus.tc !== 1'b0 || bus.running !== 1'b0)
        $display("FAIL sat_hold_%0d got q=%0d tc=%b run=%b want 3 0 0",
                 i, bus.q, bus.tc, bus.running);
      else passed++;
    end
    bus.load = 1'b1;
    bus.d    = 7'd0;
    step();
    bus.load = 1'b0;
    total++;
    if (bus.q !== 7'd0 || bus.tc !== 1'b0 || bus.running !== 1'b1)
      $display("FAIL sat_reload got q=%0d tc=%b run=%b want 0 0 1",
               bus.q, bus.tc, bus.running);
    else passed++;
    step();
    total++;
    if (bus.q !== 7'd1)
      $display("FAIL sat_resume got q=%0d want 1", bus.q);
    else passed++;
    bus.en = 1'b0;
  endtask
`endif

  task automatic test_load_priority();
    bus.en    = 1'b0;
    bus.load  = 1'b1;
    bus.d     = 7'd3;
    bus.limit = 7'd110;
    step();
    total++;
    if (bus.q !== 7'd3)
      $display("FAIL ldp_pre got q=%0d want 3", bus.q);
    else passed++;
    bus.en = 1'b1;
    bus.d  = 7'd100;
    step();
    bus.load = 1'b0;
    bus.en   = 1'b0;
    total++;
    if (bus.q !== 7'd100 || bus.tc !== 1'b0 || bus.oor !== 1'b0)
      $display("FAIL ldp got q=%0d tc=%b oor=%b want 100 0 0",
               bus.q, bus.tc, bus.oor);
    else passed++;
  endtask

  task automatic test_oor();
    logic [6:0] eq;
    bus.en    = 1'b0;
    bus.load  = 1'b1;
    bus.d     = 7'd120;
    bus.limit = 7'd10;
    step();
    bus.load = 1'b0;
    total++;
    if (bus.q !== 7'd120 || bus.oor !== 1'b1 || bus.tc !== 1'b0)
      $display("FAIL oor_load got q=%0d oor=%b tc=%b want 120 1 0",
               bus.q, bus.oor, bus.tc);
    else passed++;
    bus.en = 1'b1;
    // 121..127, 0, 1..10: eighteen edges, no tc
    for (int i = 0; i < 18; i++) begin
      step();
      eq = (i < 7) ? 7'(121 + i) : 7'(i - 7);
      total++;
      if (bus.q !== eq || bus.tc !== 1'b0 || bus.oor !== 1'b1)
        $display("FAIL oor_run_%0d got q=%0d tc=%b oor=%b want %0d 0 1",
                 i, bus.q, bus.tc, bus.oor, eq);
      else passed++;
    end
    step();
`ifdef UP_COUNTER_7BIT_SAT_EN
    eq = 7'd10;
`else
    eq = 7'd0;
`endif
    total++;
    if (bus.q !== eq || bus.tc !== 1'b1 || bus.oor !== 1'b1)
      $display("FAIL oor_term got q=%0d tc=%b oor=%b want %0d 1 1",
               bus.q, bus.tc, bus.oor, eq);
    else passed++;
    bus.en   = 1'b0;
    bus.load = 1'b1;
    bus.d    = 7'd4;
    step();
    bus.load = 1'b0;
    total++;
    if (bus.q !== 7'd4 || bus.oor !== 1'b0)
      $display("FAIL oor_clear got q=%0d oor=%b want 4 0", bus.q, bus.oor);
    else passed++;
  endtask

  task automatic test_limit_zero();
    logic et;
    logic er;
    bus.en    = 1'b0;
    bus.load  = 1'b1;
    bus.d     = 7'd0;
    bus.limit = 7'd0;
    step();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef UP_COUNTER_7BIT_SAT_EN
      et = (i == 0);
      er = 1'b0;
`else
      et = 1'b1;
      er = 1'b1;
`endif
      total++;
      if (bus.q !== 7'd0 || bus.tc !== et || bus.running !== er)
        $display("FAIL lim0_%0d got q=%0d tc=%b run=%b want 0 %b %b",
                 i, bus.q, bus.tc, bus.running, et, er);
      else passed++;
    end
    bus.en = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.en    = 1'b0;
    bus.load  = 1'b1;
    bus.d     = 7'd42;
    bus.limit = 7'd10;
    step();
    bus.load = 1'b0;
    bus.en   = 1'b1;
    total++;
    if (bus.q !== 7'd42 || bus.oor !== 1'b1)
      $display("FAIL arst_pre got q=%0d oor=%b want 42 1", bus.q, bus.oor);
    else passed++;
    #4;
    reset = 1'b0;
    #1;
    total++;
    if (bus.q !== 7'd0 || bus.tc !== 1'b0 ||
        bus.running !== 1'b0 || bus.oor !== 1'b0)
      $display("FAIL arst got q=%0d tc=%b run=%b oor=%b want 0 0 0 0",
               bus.q, bus.tc, bus.running, bus.oor);
    else passed++;
    bus.en = 1'b0;
    #2;
    reset = 1'b1;
    step();
    total++;
    if (bus.q !== 7'd0 || bus.running !== 1'b0)
      $display("FAIL arst_idle got q=%0d run=%b want 0 0",
               bus.q, bus.running);
    else passed++;
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    total++;
    if (bus.q !== 7'd1 || bus.running !== 1'b1)
      $display("FAIL arst_resume got q=%0d run=%b want 1 1",
               bus.q, bus.running);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_count();
`ifndef UP_COUNTER_7BIT_SAT_EN
    test_wrap();
`else
    test_sat();
`endif
    test_load_priority();
    test_oor();
    test_limit_zero();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
